// File: rtl/q_bus_skid.sv
// Two-entry registered skid buffer for the 18-bit S-box Q bus, carrying mode and tag
// alongside the data, with saturating stall and wrapping beat counters.
module q_bus_skid #(
    parameter int DATA_W = 18,
    parameter int TAG_W  = 4,
    parameter int CNT_W  = 16
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              flush,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [DATA_W-1:0] in_q,
    input  logic              in_mode,
    input  logic [TAG_W-1:0]  in_tag,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [DATA_W-1:0] out_q,
    output logic              out_mode,
    output logic [TAG_W-1:0]  out_tag,
    output logic [1:0]        occupancy,
    output logic [CNT_W-1:0]  stall_cnt,
    output logic [CNT_W-1:0]  beat_cnt
);

    logic              main_valid_q, main_valid_d;
    logic [DATA_W-1:0] main_q_q, main_q_d;
    logic              main_mode_q, main_mode_d;
    logic [TAG_W-1:0]  main_tag_q, main_tag_d;
    logic              skid_valid_q, skid_valid_d;
    logic [DATA_W-1:0] skid_q_q, skid_q_d;
    logic              skid_mode_q, skid_mode_d;
    logic [TAG_W-1:0]  skid_tag_q, skid_tag_d;
    logic [CNT_W-1:0]  stall_cnt_q, stall_cnt_d;
    logic [CNT_W-1:0]  beat_cnt_q, beat_cnt_d;
    logic              accept_s;
    logic              drain_s;

    // in_ready depends only on registered skid state and flush, never on out_ready
    assign in_ready  = ~skid_valid_q & ~flush;
    assign accept_s  = in_valid & in_ready;
    assign drain_s   = main_valid_q & out_ready;
    assign out_valid = main_valid_q;
    assign out_q     = main_q_q;
    assign out_mode  = main_mode_q;
    assign out_tag   = main_tag_q;
    assign occupancy = {1'b0, main_valid_q} + {1'b0, skid_valid_q};
    assign stall_cnt = stall_cnt_q;
    assign beat_cnt  = beat_cnt_q;

    // Next-state for main/skid entries
    always_comb begin
        main_valid_d = main_valid_q;
        main_q_d     = main_q_q;
        main_mode_d  = main_mode_q;
        main_tag_d   = main_tag_q;
        skid_valid_d = skid_valid_q;
        skid_q_d     = skid_q_q;
        skid_mode_d  = skid_mode_q;
        skid_tag_d   = skid_tag_q;
        if (flush) begin
            main_valid_d = 1'b0;
            skid_valid_d = 1'b0;
        end else if (!main_valid_q) begin
            if (accept_s) begin
                main_valid_d = 1'b1;
                main_q_d     = in_q;
                main_mode_d  = in_mode;
                main_tag_d   = in_tag;
            end else begin
                main_valid_d = 1'b0;
            end
        end else if (drain_s) begin
            if (skid_valid_q) begin
                // Skid is older than anything arriving now, so it moves up first
                main_q_d     = skid_q_q;
                main_mode_d  = skid_mode_q;
                main_tag_d   = skid_tag_q;
                skid_valid_d = 1'b0;
            end else if (accept_s) begin
                main_q_d     = in_q;
                main_mode_d  = in_mode;
                main_tag_d   = in_tag;
            end else begin
                main_valid_d = 1'b0;
            end
        end else begin
            if (accept_s) begin
                skid_valid_d = 1'b1;
                skid_q_d     = in_q;
                skid_mode_d  = in_mode;
                skid_tag_d   = in_tag;
            end else begin
                skid_valid_d = skid_valid_q;
            end
        end
    end

    // Next-state for characterisation counters (unaffected by flush)
    always_comb begin
        stall_cnt_d = stall_cnt_q;
        beat_cnt_d  = beat_cnt_q;
        if (main_valid_q && !out_ready && (stall_cnt_q != {CNT_W{1'b1}})) begin
            stall_cnt_d = stall_cnt_q + {{(CNT_W-1){1'b0}}, 1'b1};
        end else begin
            stall_cnt_d = stall_cnt_q;
        end
        if (drain_s) begin
            beat_cnt_d = beat_cnt_q + {{(CNT_W-1){1'b0}}, 1'b1};
        end else begin
            beat_cnt_d = beat_cnt_q;
        end
    end

    // State registers
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            main_valid_q <= 1'b0;
            main_q_q     <= {DATA_W{1'b0}};
            main_mode_q  <= 1'b0;
            main_tag_q   <= {TAG_W{1'b0}};
            skid_valid_q <= 1'b0;
            skid_q_q     <= {DATA_W{1'b0}};
            skid_mode_q  <= 1'b0;
            skid_tag_q   <= {TAG_W{1'b0}};
            stall_cnt_q  <= {CNT_W{1'b0}};
            beat_cnt_q   <= {CNT_W{1'b0}};
        end else begin
            main_valid_q <= main_valid_d;
            main_q_q     <= main_q_d;
            main_mode_q  <= main_mode_d;
            main_tag_q   <= main_tag_d;
            skid_valid_q <= skid_valid_d;
            skid_q_q     <= skid_q_d;
            skid_mode_q  <= skid_mode_d;
            skid_tag_q   <= skid_tag_d;
            stall_cnt_q  <= stall_cnt_d;
            beat_cnt_q   <= beat_cnt_d;
        end
    end

endmodule

// File: tb/tb_q_bus_skid.sv
// Directed self-checking bench for q_bus_skid (counters narrowed to 4 bits).
module tb_q_bus_skid;

    localparam int DATA_W = 18;
    localparam int TAG_W  = 4;
    localparam int CNT_W  = 4;

    logic              clk;
    logic              rst;
    logic              flush;
    logic              in_valid;
    logic              in_ready;
    logic [DATA_W-1:0] in_q;
    logic              in_mode;
    logic [TAG_W-1:0]  in_tag;
    logic              out_valid;
    logic              out_ready;
    logic [DATA_W-1:0] out_q;
    logic              out_mode;
    logic [TAG_W-1:0]  out_tag;
    logic [1:0]        occupancy;
    logic [CNT_W-1:0]  stall_cnt;
    logic [CNT_W-1:0]  beat_cnt;

    int checks;
    int failures;

    q_bus_skid #(.DATA_W(DATA_W), .TAG_W(TAG_W), .CNT_W(CNT_W)) dut (
        .clk(clk), .rst(rst), .flush(flush),
        .in_valid(in_valid), .in_ready(in_ready), .in_q(in_q), .in_mode(in_mode), .in_tag(in_tag),
        .out_valid(out_valid), .out_ready(out_ready), .out_q(out_q), .out_mode(out_mode), .out_tag(out_tag),
        .occupancy(occupancy), .stall_cnt(stall_cnt), .beat_cnt(beat_cnt)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic send(input logic [DATA_W-1:0] q, input logic [TAG_W-1:0] t, input logic m);
        in_valid = 1'b1;
        in_q     = q;
        in_tag   = t;
        in_mode  = m;
    endtask

    task automatic do_reset();
        rst = 1'b1; flush = 1'b0; in_valid = 1'b0; in_q = '0; in_mode = 1'b0; in_tag = '0;
        out_ready = 1'b0;
        tick();
        tick();
        rst = 1'b0;
        #1;
    endtask

    task automatic test_reset();
        do_reset();
        checks++; if (out_valid !== 1'b0) begin failures++; $display("FAIL rst_out_valid got=%0b exp=0", out_valid); end
        checks++; if (out_q !== 18'h00000) begin failures++; $display("FAIL rst_out_q got=%h exp=0", out_q); end
        checks++; if ({out_mode, out_tag} !== 5'd0) begin failures++; $display("FAIL rst_mode_tag got=%b/%h exp=0", out_mode, out_tag); end
        checks++; if (occupancy !== 2'd0) begin failures++; $display("FAIL rst_occ got=%0d exp=0", occupancy); end
        checks++; if ({stall_cnt, beat_cnt} !== 8'd0) begin failures++; $display("FAIL rst_cnt got=%0d/%0d exp=0/0", stall_cnt, beat_cnt); end
        checks++; if (in_ready !== 1'b1) begin failures++; $display("FAIL rst_in_ready got=%0b exp=1", in_ready); end
    endtask

    task automatic test_stream();
        logic [DATA_W-1:0] eq;
        logic [TAG_W-1:0]  et;
        do_reset();
        out_ready = 1'b1;
        for (int i = 0; i < 8; i++) begin
            eq = DATA_W'(i + 1);
            et = TAG_W'(i);
            send(eq, et, et[0]);
            tick();
            checks++;
            if (out_valid !== 1'b1 || out_q !== eq || out_tag !== et || out_mode !== et[0] ||
                occupancy !== 2'd1 || in_ready !== 1'b1) begin
                failures++;
                $display("FAIL stream_%0d got v=%0b q=%h t=%h m=%0b occ=%0d rdy=%0b exp v=1 q=%h t=%h m=%0b occ=1 rdy=1",
                         i, out_valid, out_q, out_tag, out_mode, occupancy, in_ready, eq, et, et[0]);
            end
        end
        in_valid = 1'b0;
        tick();
        checks++; if (out_valid !== 1'b0) begin failures++; $display("FAIL stream_empty got=%0b exp=0", out_valid); end
        checks++; if (beat_cnt !== 4'd8) begin failures++; $display("FAIL stream_beats got=%0d exp=8", beat_cnt); end
        checks++; if (stall_cnt !== 4'd0) begin failures++; $display("FAIL stream_stalls got=%0d exp=0", stall_cnt); end
    endtask

    task automatic test_fill_drain();
        do_reset();
        send(18'h3FFFF, 4'd1, 1'b0);
        tick();
        checks++; if (occupancy !== 2'd1 || in_ready !== 1'b1) begin failures++; $display("FAIL fill_one got occ=%0d rdy=%0b exp occ=1 rdy=1", occupancy, in_ready); end
        send(18'h2AAAA, 4'd2, 1'b1);
        tick();
        in_valid = 1'b0;
        checks++; if (occupancy !== 2'd2 || in_ready !== 1'b0) begin failures++; $display("FAIL fill_two got occ=%0d rdy=%0b exp occ=2 rdy=0", occupancy, in_ready); end
        tick();
        tick();
        checks++; if (out_q !== 18'h3FFFF || out_tag !== 4'd1 || out_valid !== 1'b1) begin failures++; $display("FAIL fill_hold got q=%h t=%h v=%0b exp q=3ffff t=1 v=1", out_q, out_tag, out_valid); end
        checks++; if (stall_cnt !== 4'd3) begin failures++; $display("FAIL fill_stall got=%0d exp=3", stall_cnt); end
        out_ready = 1'b1;
        tick();
        checks++; if (out_q !== 18'h2AAAA || out_tag !== 4'd2 || out_mode !== 1'b1 || occupancy !== 2'd1 || in_ready !== 1'b1) begin
            failures++; $display("FAIL drain_first got q=%h t=%h m=%0b occ=%0d rdy=%0b exp q=2aaaa t=2 m=1 occ=1 rdy=1", out_q, out_tag, out_mode, occupancy, in_ready);
        end
        tick();
        checks++; if (out_valid !== 1'b0 || beat_cnt !== 4'd2) begin failures++; $display("FAIL drain_second got v=%0b beats=%0d exp v=0 beats=2", out_valid, beat_cnt); end
    endtask

    task automatic test_back_to_back();
        do_reset();
        out_ready = 1'b1;
        send(18'h0AAAA, 4'd3, 1'b0);
        tick();
        send(18'h15555, 4'd4, 1'b1);
        tick();
        in_valid = 1'b0;
        checks++; if (out_q !== 18'h15555 || out_tag !== 4'd4 || occupancy !== 2'd1 || beat_cnt !== 4'd1) begin
            failures++; $display("FAIL b2b got q=%h t=%h occ=%0d beats=%0d exp q=15555 t=4 occ=1 beats=1", out_q, out_tag, occupancy, beat_cnt);
        end
        tick();
        checks++; if (beat_cnt !== 4'd2 || out_valid !== 1'b0) begin failures++; $display("FAIL b2b_end got beats=%0d v=%0b exp beats=2 v=0", beat_cnt, out_valid); end
    endtask

    task automatic test_flush();
        do_reset();
        send(18'h11111, 4'd5, 1'b0);
        tick();
        send(18'h22222, 4'd6, 1'b0);
        tick();
        out_ready = 1'b1;
        flush = 1'b1;
        send(18'h33333, 4'd7, 1'b1);
        #1;
        checks++; if (in_ready !== 1'b0) begin failures++; $display("FAIL flush_rdy got=%0b exp=0", in_ready); end
        tick();
        flush = 1'b0;
        in_valid = 1'b0;
        checks++; if (out_valid !== 1'b0 || occupancy !== 2'd0 || beat_cnt !== 4'd1) begin
            failures++; $display("FAIL flush got v=%0b occ=%0d beats=%0d exp v=0 occ=0 beats=1", out_valid, occupancy, beat_cnt);
        end
        tick();
        checks++; if (out_valid !== 1'b0 || beat_cnt !== 4'd1) begin failures++; $display("FAIL flush_after got v=%0b beats=%0d exp v=0 beats=1", out_valid, beat_cnt); end
    endtask

    task automatic test_counters();
        do_reset();
        send(18'h00100, 4'd0, 1'b0);
        tick();
        in_valid = 1'b0;
        for (int i = 0; i < 20; i++) tick();
        checks++; if (stall_cnt !== 4'd15) begin failures++; $display("FAIL stall_sat got=%0d exp=15", stall_cnt); end
        out_ready = 1'b1;
        for (int i = 0; i < 16; i++) begin
            send(DATA_W'(i + 18'h00200), TAG_W'(i), 1'b0);
            tick();
        end
        in_valid = 1'b0;
        tick();
        checks++; if (beat_cnt !== 4'd1) begin failures++; $display("FAIL beat_wrap got=%0d exp=1", beat_cnt); end
        checks++; if (stall_cnt !== 4'd15 || out_valid !== 1'b0) begin failures++; $display("FAIL cnt_end got stall=%0d v=%0b exp stall=15 v=0", stall_cnt, out_valid); end
    endtask

    task automatic test_async_reset();
        do_reset();
        send(18'h0F0F0, 4'd9, 1'b1);
        tick();
        send(18'h30303, 4'd10, 1'b1);
        tick();
        in_valid = 1'b0;
        checks++; if (occupancy !== 2'd2) begin failures++; $display("FAIL arst_pre got occ=%0d exp=2", occupancy); end
        #2;
        rst = 1'b1;
        #1;
        checks++; if (out_valid !== 1'b0 || out_q !== 18'h00000 || occupancy !== 2'd0 || out_tag !== 4'd0 || out_mode !== 1'b0) begin
            failures++; $display("FAIL arst_now got v=%0b q=%h occ=%0d t=%h m=%0b exp all 0", out_valid, out_q, occupancy, out_tag, out_mode);
        end
        checks++; if (stall_cnt !== 4'd0 || beat_cnt !== 4'd0) begin failures++; $display("FAIL arst_cnt got %0d/%0d exp 0/0", stall_cnt, beat_cnt); end
        @(negedge clk);
        rst = 1'b0;
        out_ready = 1'b1;
        tick();
        checks++; if (out_valid !== 1'b0 || in_ready !== 1'b1) begin failures++; $display("FAIL arst_after got v=%0b rdy=%0b exp v=0 rdy=1", out_valid, in_ready); end
    endtask

    initial begin
        checks = 0;
        failures = 0;
        test_reset();
        test_stream();
        test_fill_drain();
        test_back_to_back();
        test_flush();
        test_counters();
        test_async_reset();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
